// File: rtl/program_loader_pkg.sv
// program_loader_pkg
// Shared types and constants for the program loader.
//   state_t        : loader FSM states
//   BYTES_PER_WORD : bytes assembled into one instruction word
//   DEF_ADDR_W     : default instruction-memory address width
//   DEF_DATA_W     : default instruction word width
//   CNT_W          : width of the word count / words-written counters
//   decode_count() : maps the count byte to a word count (0 means 256)
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_COUNT,
        GET_BYTES,
        WRITE,
        GET_CSUM,
        DONE,
        ERROR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_DATA_W     = 32;
    localparam int CNT_W          = 9;

    // A zero count byte stands for a full 256-word image.
    function automatic logic [CNT_W-1:0] decode_count(input logic [7:0] count_byte);
        return (count_byte == 8'd0) ? CNT_W'(256) : {1'b0, count_byte};
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// word_assembler
// Shifts incoming bytes MSB-first into an instruction word and flags the
// byte that completes it.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN (adds the 8-bit running
// sum of all shifted bytes and its output port).
// Ports:
//   clk        : clock
//   reset      : synchronous active-high reset
//   clear      : synchronous clear at the start of a load
//   shift_en   : a data byte is accepted this cycle
//   data       : the byte being accepted
//   word       : assembled word, most recent byte in the low lane
//   word_ready : shift_en on the last byte of a word
//   sum        : modulo-256 sum of bytes since clear (feature only)
module word_assembler
    import program_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        data,
    output logic [DATA_W-1:0] word,
    output logic              word_ready
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]        sum
`endif
);

    logic [1:0] byte_idx;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word     <= '0;
            byte_idx <= 2'd0;
        end else if (shift_en) begin
            word     <= {word[DATA_W-9:0], data};
            byte_idx <= byte_idx + 2'd1;
        end
    end

    assign word_ready = shift_en && (byte_idx == 2'(BYTES_PER_WORD - 1));

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sum <= 8'd0;
        end else if (shift_en) begin
            sum <= sum + data;
        end
    end
`endif

endmodule

// File: rtl/program_loader.sv
// program_loader
// Receives a program image as a byte stream (count byte, then 4 bytes per
// word MSB first), writes each word into instruction memory from BASE_ADDR
// upward, and holds the CPU in reset until the image is loaded.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN (a trailing checksum
// byte must equal the modulo-256 sum of the data bytes, else ERROR).
// Ports:
//   MAX10_CLK1_50 : clock
//   reset         : synchronous active-high reset
//   start         : pulse, begins a load from IDLE, DONE or ERROR
//   rx_data/valid : incoming byte stream
//   rx_ready      : byte accepted when rx_valid && rx_ready
//   imem_addr     : instruction-memory write address
//   imem_wdata    : instruction word
//   imem_we       : one-cycle write strobe per word
//   cpu_hold      : 1 holds the CPU in reset (all states but DONE)
//   done / error  : sticky load status
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | after reset, waiting for start
// GET_COUNT | receiving the word-count byte
// GET_BYTES | receiving bytes of the current word
// WRITE     | one-cycle write of the assembled word
// GET_CSUM  | receiving the checksum byte (feature only)
// DONE      | image loaded, CPU released
// ERROR     | checksum mismatch, CPU held (feature only)
module program_loader
    import program_loader_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DATA_W    = DEF_DATA_W
) (
    input  logic              MAX10_CLK1_50,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              imem_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] count_n;
    logic [CNT_W-1:0] words;
    logic             byte_acc;
    logic             shift_en;
    logic             word_ready;
    logic             clear_asm;
    logic             last_word;

    // Ready depends on the registered state only, so there is no path
    // from rx_valid back to rx_ready.
    assign rx_ready  = (state == GET_COUNT) || (state == GET_BYTES) || (state == GET_CSUM);
    assign byte_acc  = rx_valid && rx_ready;
    assign shift_en  = byte_acc && (state == GET_BYTES);
    assign last_word = (words + CNT_W'(1)) == count_n;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] sum;

    word_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk        (MAX10_CLK1_50),
        .reset      (reset),
        .clear      (clear_asm),
        .shift_en   (shift_en),
        .data       (rx_data),
        .word       (imem_wdata),
        .word_ready (word_ready),
        .sum        (sum)
    );
`else
    word_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk        (MAX10_CLK1_50),
        .reset      (reset),
        .clear      (clear_asm),
        .shift_en   (shift_en),
        .data       (rx_data),
        .word       (imem_wdata),
        .word_ready (word_ready)
    );
`endif

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            state     <= IDLE;
            imem_addr <= BASE_ADDR;
            count_n   <= '0;
            words     <= '0;
        end else begin
            state <= state_nx;
            if (clear_asm) begin
                imem_addr <= BASE_ADDR;
                words     <= '0;
            end
            if ((state == GET_COUNT) && byte_acc) begin
                count_n <= decode_count(rx_data);
            end
            if (state == WRITE) begin
                imem_addr <= imem_addr + 1'b1;
                words     <= words + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nx  = state;
        clear_asm = 1'b0;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_nx  = GET_COUNT;
                    clear_asm = 1'b1;
                end
            end
            GET_COUNT: begin
                if (byte_acc) state_nx = GET_BYTES;
            end
            GET_BYTES: begin
                if (word_ready) state_nx = WRITE;
            end
            WRITE: begin
                if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_nx = GET_CSUM;
`else
                    state_nx = DONE;
`endif
                end else begin
                    state_nx = GET_BYTES;
                end
            end
            GET_CSUM: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (byte_acc) state_nx = (rx_data == sum) ? DONE : ERROR;
`else
                state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    assign imem_we  = (state == WRITE);
    assign cpu_hold = (state != DONE);
    assign done     = (state == DONE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign error    = (state == ERROR);
`else
    assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    localparam logic [7:0] BASE0 = 8'h00;
    localparam logic [1:0] BASE1 = 2'd2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic        rdy0, we0, hold0, done0, err0;
    logic [7:0]  addr0;
    logic [31:0] data0;
    logic        rdy1, we1, hold1, done1, err1;
    logic [1:0]  addr1;
    logic [31:0] data1;

    always #10 clk = ~clk;

    program_loader #(.ADDR_W(8), .BASE_ADDR(BASE0), .DATA_W(32)) dut (
        .MAX10_CLK1_50 (clk),
        .reset         (reset),
        .start         (start),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rdy0),
        .imem_addr     (addr0),
        .imem_wdata    (data0),
        .imem_we       (we0),
        .cpu_hold      (hold0),
        .done          (done0),
        .error         (err0)
    );

    // Narrow-address copy with a non-zero base to exercise address wrap.
    program_loader #(.ADDR_W(2), .BASE_ADDR(BASE1), .DATA_W(32)) dut_wrap (
        .MAX10_CLK1_50 (clk),
        .reset         (reset),
        .start         (start),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rdy1),
        .imem_addr     (addr1),
        .imem_wdata    (data1),
        .imem_we       (we1),
        .cpu_hold      (hold1),
        .done          (done1),
        .error         (err1)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    bit          mon_en = 0, in_load = 0, exp_we = 0, exp_done = 0, exp_err = 0;
    int          idx = 0, cnt_n = 0, words_done = 0;
    logic [31:0] word_acc = '0, exp_data = '0;
    logic [7:0]  exp_addr0 = '0, sum = '0;
    logic [1:0]  exp_addr1 = '0;
    logic [31:0] mem0 [256];
    int          wr_count = 0;

    always @(negedge clk) begin
        bit hs, was_we;
        hs = rx_valid && rdy0;
        if (mon_en) begin
            check("imem_we", {31'd0, we0}, {31'd0, exp_we});
            check("imem_we_wrap", {31'd0, we1}, {31'd0, exp_we});
            if (exp_we) begin
                check("imem_addr", {24'd0, addr0}, {24'd0, exp_addr0});
                check("imem_wdata", data0, exp_data);
                check("imem_addr_wrap", {30'd0, addr1}, {30'd0, exp_addr1});
                check("imem_wdata_wrap", data1, exp_data);
            end
            check("rx_ready", {31'd0, rdy0}, {31'd0, in_load && !exp_we});
            check("rx_ready_wrap", {31'd0, rdy1}, {31'd0, in_load && !exp_we});
            check("done", {31'd0, done0}, {31'd0, exp_done});
            check("error", {31'd0, err0}, {31'd0, exp_err});
            check("cpu_hold", {31'd0, hold0}, {31'd0, !exp_done});
            check("cpu_hold_wrap", {31'd0, hold1}, {31'd0, !exp_done});
            if (we0) begin
                mem0[addr0] = data0;
                wr_count++;
            end
        end
        if (reset) begin
            mon_en = 1; in_load = 0; exp_we = 0; exp_done = 0; exp_err = 0;
            idx = 0; words_done = 0;
        end else begin
            was_we = exp_we;
            exp_we = 0;
            if (was_we) begin
                words_done++;
                if (words_done == cnt_n && !CSUM_EN) begin
                    in_load  = 0;
                    exp_done = 1;
                end
            end
            if (start && !in_load) begin
                in_load = 1; idx = 0; words_done = 0; exp_done = 0; exp_err = 0;
                word_acc = '0; sum = '0;
            end else if (hs && in_load) begin
                if (idx == 0) begin
                    cnt_n = (rx_data == 8'd0) ? 256 : int'(rx_data);
                end else if (idx <= 4 * cnt_n) begin
                    word_acc = {word_acc[23:0], rx_data};
                    sum      = sum + rx_data;
                    if (idx % 4 == 0) begin
                        exp_we    = 1;
                        exp_data  = word_acc;
                        exp_addr0 = 8'(int'(BASE0) + words_done);
                        exp_addr1 = 2'(int'(BASE1) + words_done);
                    end
                end else begin
                    in_load = 0;
                    if (rx_data == sum) exp_done = 1;
                    else exp_err = 1;
                end
                idx++;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] byte_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got;
        int n;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) tick();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        got = 0;
        n = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            got = rdy0;
            n++;
        end
        if (!got) timeout_fail("rx_ready_wait");
        tick();
    endtask

    function automatic logic [7:0] image_sum();
        logic [7:0] s;
        s = 8'd0;
        for (int i = 1; i < byte_q.size(); i++) s = s + byte_q[i];
        return s;
    endfunction

    task automatic load(input int max_gap, input logic [7:0] csum);
        bit fin;
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < byte_q.size(); i++) begin
            send_byte(byte_q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
        if (CSUM_EN) send_byte(csum, 0);
        rx_valid = 1'b0;
        fin = 0;
        n = 0;
        while (!fin && n < 20) begin
            @(negedge clk);
            fin = done0 || err0;
            n++;
        end
        if (!fin) timeout_fail("load_finish");
        tick();
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held two cycles
        repeat (2) tick();
        @(negedge clk);
        check("rst_rx_ready", {31'd0, rdy0}, 32'd0);
        check("rst_imem_we", {31'd0, we0}, 32'd0);
        check("rst_imem_addr", {24'd0, addr0}, 32'd0);
        check("rst_imem_wdata", data0, 32'd0);
        check("rst_cpu_hold", {31'd0, hold0}, 32'd1);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_error", {31'd0, err0}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // two-word image, rx_valid held high throughout
        byte_q = {8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        wr_count = 0;
        load(0, image_sum());
        check("t2_writes", wr_count, 32'd2);
        check("t2_word0", mem0[0], 32'h11223344);
        check("t2_word1", mem0[1], 32'hAABBCCDD);
        check("t2_done", {31'd0, done0}, 32'd1);
        check("t2_hold", {31'd0, hold0}, 32'd0);

        // same image with random valid gaps
        mem0[0] = '0;
        mem0[1] = '0;
        wr_count = 0;
        load(5, image_sum());
        check("t3_writes", wr_count, 32'd2);
        check("t3_word0", mem0[0], 32'h11223344);
        check("t3_word1", mem0[1], 32'hAABBCCDD);

        // count byte 00 -> 256 words
        byte_q = {8'h00};
        for (int i = 0; i < 1024; i++) byte_q.push_back(8'(i));
        wr_count = 0;
        load(0, image_sum());
        check("t4_writes", wr_count, 32'd256);
        check("t4_word00", mem0[8'h00], 32'h00010203);
        check("t4_word80", mem0[8'h80], 32'h00010203 + 32'h04040404 * 32'h0);
        check("t4_wordFF", mem0[8'hFF], 32'hFCFDFEFF);
        check("t4_done", {31'd0, done0}, 32'd1);

        // reset in the middle of a word: nothing written
        wr_count = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rx_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t5_no_write", wr_count, 32'd0);
        check("t5_idle_ready", {31'd0, rdy0}, 32'd0);
        check("t5_idle_hold", {31'd0, hold0}, 32'd1);
        check("t5_idle_done", {31'd0, done0}, 32'd0);
        tick();
        byte_q = {8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        load(2, image_sum());
        check("t5_writes", wr_count, 32'd1);
        check("t5_word0", mem0[0], 32'hDEADBEEF);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        byte_q = {8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        load(0, 8'h0A);
        check("t6_good_done", {31'd0, done0}, 32'd1);
        check("t6_good_error", {31'd0, err0}, 32'd0);
        load(1, 8'h0B);
        check("t6_bad_error", {31'd0, err0}, 32'd1);
        check("t6_bad_done", {31'd0, done0}, 32'd0);
        check("t6_bad_hold", {31'd0, hold0}, 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("t6_start_clears_error", {31'd0, err0}, 32'd0);
        check("t6_start_ready", {31'd0, rdy0}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
`endif

        // sanity on the model's own arithmetic for the 256-word pattern
        check("t4_word80_lit", mem0[8'h80], 32'h00010203);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
